// File: rtl/csi_frame_ctrl_if.sv
// ---------------------------------------------------------------------------
// csi_frame_ctrl_if
// Stream bundle between the CSI-2 packet handler, the frame-capture
// controller and the frame-buffer write path.
//   raw_vld/raw_data    : handler word stream (contiguous words per long packet)
//   raw_vsync           : one-cycle frame-start strobe (FS short packet)
//   packet_done         : one-cycle end-of-packet strobe
//   pix_vld/pix_data    : registered captured words (data 0 when not valid)
//   frame_start         : pulse on the first cycle of a captured frame
//   line_end            : pulse after the last word of each captured line
//   frame_end           : pulse when a captured frame terminates
// Modports:
//   master : handler / write-path side (drives raw_*, receives pix_*)
//   slave  : controller side
// ---------------------------------------------------------------------------
interface csi_frame_ctrl_if;
    logic        raw_vld;
    logic [15:0] raw_data;
    logic        raw_vsync;
    logic        packet_done;
    logic        pix_vld;
    logic [15:0] pix_data;
    logic        frame_start;
    logic        line_end;
    logic        frame_end;

    modport master (
        output raw_vld, raw_data, raw_vsync, packet_done,
        input  pix_vld, pix_data, frame_start, line_end, frame_end
    );

    modport slave (
        input  raw_vld, raw_data, raw_vsync, packet_done,
        output pix_vld, pix_data, frame_start, line_end, frame_end
    );
endinterface

// File: rtl/csi_frame_ctrl.sv
// ---------------------------------------------------------------------------
// csi_frame_ctrl
// Frame-capture controller between the CSI-2 packet handler and the
// frame-buffer write path. Arms on cap_req, gates one frame (or frames
// continuously) aligned to frame start, forwards words with a one-cycle
// register stage and reports malformed lines/frames and stalls.
//
// Optional feature macro: FRAME_CTRL_LINE_CHK_EN
//   defined     : per-line word count checked against H_WORDS -> err_len
//   not defined : no word counter, err_len tied low
//
// Ports:
//   sclk, s_rst  : clock, synchronous active-high reset
//   csi          : stream interface (slave modport), see csi_frame_ctrl_if
//   cap_req      : one-cycle capture request (ignored while busy)
//   cap_cont     : continuous-mode level, sampled with cap_req
//   cap_stop     : one-cycle stop request
//   err_clr      : clears sticky error flags
//   line_cnt     : lines completed in the current frame
//   cap_busy     : high while ARMED or ACTIVE
//   cap_done     : pulse when the controller returns to IDLE
//   err_len/err_frame/err_tmo : sticky error flags
// ---------------------------------------------------------------------------
module csi_frame_ctrl #(
    parameter int H_WORDS = 1280,
    parameter int V_LINES = 720,
    parameter int TMO_CYC = 65535,
    parameter int LCW     = 12
) (
    input  logic                 sclk,
    input  logic                 s_rst,
    csi_frame_ctrl_if.slave      csi,
    input  logic                 cap_req,
    input  logic                 cap_cont,
    input  logic                 cap_stop,
    input  logic                 err_clr,
    output logic [LCW-1:0]       line_cnt,
    output logic                 cap_busy,
    output logic                 cap_done,
    output logic                 err_len,
    output logic                 err_frame,
    output logic                 err_tmo
);
    localparam int TCW = $clog2(TMO_CYC + 1);

    typedef enum logic [1:0] {IDLE, ARMED, ACTIVE} state_t;

    state_t           state_q, state_d;
    logic             cont_q, cont_d;
    logic             raw_vld_d1_q;
    logic [LCW-1:0]   line_cnt_q, line_cnt_d, line_cnt_inc;
    logic [TCW-1:0]   tmo_q, tmo_d, tmo_inc;
    logic             pix_vld_q, pix_vld_d;
    logic [15:0]      pix_data_q, pix_data_d;
    logic             fs_q, fs_d, le_q, le_d, fe_q, fe_d, cd_q, cd_d;
    logic             err_frame_q, err_frame_d, err_tmo_q, err_tmo_d;
    logic             line_evt, keep_cont, end_frame, tmo_hit;
`ifdef FRAME_CTRL_LINE_CHK_EN
    localparam int WCW = $clog2(H_WORDS) + 1;
    logic [WCW-1:0]   wcnt_q, wcnt_d;
    logic             err_len_q, err_len_d;
`endif

    assign line_cnt_inc = line_cnt_q + LCW'(1);
    assign tmo_inc      = tmo_q + TCW'(1);
    // A long packet ends when packet_done follows a valid word; a short
    // packet's packet_done has no valid word before it and is not a line.
    assign line_evt     = (state_q == ACTIVE) && csi.packet_done && raw_vld_d1_q;
    // Continuous mode survives only if no stop arrives this cycle.
    assign keep_cont    = cont_q && !cap_stop;
    assign tmo_hit      = (tmo_inc == TCW'(TMO_CYC));

    always_comb begin
        state_d     = state_q;
        cont_d      = cont_q;
        line_cnt_d  = line_cnt_q;
        tmo_d       = tmo_q;
        fs_d        = 1'b0;
        le_d        = 1'b0;
        fe_d        = 1'b0;
        cd_d        = 1'b0;
        end_frame   = 1'b0;
        // Clear first so a set event later in this block wins over err_clr.
        err_frame_d = err_frame_q && !err_clr;
        err_tmo_d   = err_tmo_q && !err_clr;
        pix_vld_d   = (state_q == ACTIVE) && csi.raw_vld;
        pix_data_d  = pix_vld_d ? csi.raw_data : 16'd0;
`ifdef FRAME_CTRL_LINE_CHK_EN
        wcnt_d      = wcnt_q;
        err_len_d   = err_len_q && !err_clr;
`endif
        if (cap_stop) cont_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (cap_req) begin
                    state_d = ARMED;
                    cont_d  = cap_cont;
                end
            end
            ARMED: begin
                if (cap_stop) begin
                    state_d = IDLE;
                    cd_d    = 1'b1;
                end else if (csi.raw_vsync) begin
                    state_d    = ACTIVE;
                    fs_d       = 1'b1;
                    line_cnt_d = '0;
                    tmo_d      = '0;
`ifdef FRAME_CTRL_LINE_CHK_EN
                    wcnt_d     = '0;
`endif
                end
            end
            ACTIVE: begin
                tmo_d = tmo_inc;
`ifdef FRAME_CTRL_LINE_CHK_EN
                if (csi.raw_vld && (wcnt_q != '1)) wcnt_d = wcnt_q + WCW'(1);
`endif
                if (line_evt) begin
                    le_d       = 1'b1;
                    line_cnt_d = line_cnt_inc;
                    tmo_d      = '0;
`ifdef FRAME_CTRL_LINE_CHK_EN
                    wcnt_d     = '0;
                    if (wcnt_q != WCW'(H_WORDS)) err_len_d = 1'b1;
`endif
                    end_frame  = (line_cnt_inc == LCW'(V_LINES));
                end

                if (!end_frame && csi.raw_vsync) begin
                    // Early frame start: close this frame as malformed.
                    err_frame_d = 1'b1;
                    fe_d        = 1'b1;
                    if (keep_cont) begin
                        fs_d       = 1'b1;
                        line_cnt_d = '0;
                        tmo_d      = '0;
`ifdef FRAME_CTRL_LINE_CHK_EN
                        wcnt_d     = '0;
`endif
                    end else begin
                        state_d = IDLE;
                        cd_d    = 1'b1;
                    end
                end else if (end_frame || (!line_evt && tmo_hit)) begin
                    fe_d = 1'b1;
                    if (!end_frame) err_tmo_d = 1'b1;
                    if (keep_cont) begin
                        state_d = ARMED;
                    end else begin
                        state_d = IDLE;
                        cd_d    = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sclk) begin
        if (s_rst) begin
            state_q      <= IDLE;
            cont_q       <= 1'b0;
            raw_vld_d1_q <= 1'b0;
            line_cnt_q   <= '0;
            tmo_q        <= '0;
            pix_vld_q    <= 1'b0;
            pix_data_q   <= 16'd0;
            fs_q         <= 1'b0;
            le_q         <= 1'b0;
            fe_q         <= 1'b0;
            cd_q         <= 1'b0;
            err_frame_q  <= 1'b0;
            err_tmo_q    <= 1'b0;
`ifdef FRAME_CTRL_LINE_CHK_EN
            wcnt_q       <= '0;
            err_len_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cont_q       <= cont_d;
            raw_vld_d1_q <= csi.raw_vld;
            line_cnt_q   <= line_cnt_d;
            tmo_q        <= tmo_d;
            pix_vld_q    <= pix_vld_d;
            pix_data_q   <= pix_data_d;
            fs_q         <= fs_d;
            le_q         <= le_d;
            fe_q         <= fe_d;
            cd_q         <= cd_d;
            err_frame_q  <= err_frame_d;
            err_tmo_q    <= err_tmo_d;
`ifdef FRAME_CTRL_LINE_CHK_EN
            wcnt_q       <= wcnt_d;
            err_len_q    <= err_len_d;
`endif
        end
    end

    assign csi.pix_vld     = pix_vld_q;
    assign csi.pix_data    = pix_data_q;
    assign csi.frame_start = fs_q;
    assign csi.line_end    = le_q;
    assign csi.frame_end   = fe_q;
    assign line_cnt        = line_cnt_q;
    assign cap_busy        = (state_q != IDLE);
    assign cap_done        = cd_q;
    assign err_frame       = err_frame_q;
    assign err_tmo         = err_tmo_q;
`ifdef FRAME_CTRL_LINE_CHK_EN
    assign err_len         = err_len_q;
`else
    assign err_len         = 1'b0;
`endif
endmodule

// File: tb/tb_csi_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_csi_frame_ctrl
// Directed bench for csi_frame_ctrl with H_WORDS=4, V_LINES=2, TMO_CYC=16.
// Forwarded words are queued when driven and popped as pix_vld appears.
// ---------------------------------------------------------------------------
module tb_csi_frame_ctrl;
    localparam int H  = 4;
    localparam int V  = 2;
    localparam int TM = 16;
    localparam int LW = 4;

    logic          sclk = 1'b0;
    logic          s_rst;
    logic          cap_req, cap_cont, cap_stop, err_clr;
    logic [LW-1:0] line_cnt;
    logic          cap_busy, cap_done, err_len, err_frame, err_tmo;

    csi_frame_ctrl_if csi ();

    csi_frame_ctrl #(.H_WORDS(H), .V_LINES(V), .TMO_CYC(TM), .LCW(LW)) dut (
        .sclk      (sclk),
        .s_rst     (s_rst),
        .csi       (csi.slave),
        .cap_req   (cap_req),
        .cap_cont  (cap_cont),
        .cap_stop  (cap_stop),
        .err_clr   (err_clr),
        .line_cnt  (line_cnt),
        .cap_busy  (cap_busy),
        .cap_done  (cap_done),
        .err_len   (err_len),
        .err_frame (err_frame),
        .err_tmo   (err_tmo)
    );

    always #5 sclk = ~sclk;

`ifdef FRAME_CTRL_LINE_CHK_EN
    localparam logic LEN_EXP = 1'b1;
`else
    localparam logic LEN_EXP = 1'b0;
`endif

    int          total = 0;
    int          bad   = 0;
    int          n_fs  = 0;
    int          n_le  = 0;
    logic [15:0] exp_q[$];
    int          fs_base;
    int          le_base;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample outputs 1 time unit after the edge.
    task automatic tick();
        logic [15:0] w;
        @(posedge sclk);
        #1;
        if (csi.frame_start === 1'b1) n_fs++;
        if (csi.line_end === 1'b1) n_le++;
        if (csi.pix_vld === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("pix_unexpected", {31'd0, csi.pix_vld}, 32'd0);
            end else begin
                w = exp_q.pop_front();
                chk("pix_data", {16'd0, csi.pix_data}, {16'd0, w});
            end
        end else begin
            chk("pix_data_zero", {16'd0, csi.pix_data}, 32'd0);
        end
    endtask

    task automatic send_fs();
        csi.raw_vsync = 1'b1;
        tick();
        csi.raw_vsync = 1'b0;
    endtask

    // Drives n words then packet_done; returns right after the packet_done
    // edge, where line_end for this line is visible.
    task automatic send_line(input int n, input logic [15:0] base, input bit fwd);
        for (int i = 0; i < n; i++) begin
            csi.raw_vld  = 1'b1;
            csi.raw_data = base + 16'(i);
            if (fwd) exp_q.push_back(base + 16'(i));
            tick();
        end
        csi.raw_vld     = 1'b0;
        csi.raw_data    = 16'd0;
        csi.packet_done = 1'b1;
        tick();
        csi.packet_done = 1'b0;
    endtask

    task automatic request(input logic cont);
        cap_req  = 1'b1;
        cap_cont = cont;
        tick();
        cap_req  = 1'b0;
        cap_cont = 1'b0;
    endtask

    task automatic stop_pulse();
        cap_stop = 1'b1;
        tick();
        cap_stop = 1'b0;
    endtask

    initial begin
        s_rst = 1'b1;
        cap_req = 1'b0; cap_cont = 1'b0; cap_stop = 1'b0; err_clr = 1'b0;
        csi.raw_vld = 1'b0; csi.raw_data = 16'd0;
        csi.raw_vsync = 1'b0; csi.packet_done = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_pix_vld", {31'd0, csi.pix_vld}, 32'd0);
        chk("rst_fs", {31'd0, csi.frame_start}, 32'd0);
        chk("rst_le", {31'd0, csi.line_end}, 32'd0);
        chk("rst_fe", {31'd0, csi.frame_end}, 32'd0);
        chk("rst_line_cnt", {28'd0, line_cnt}, 32'd0);
        chk("rst_busy", {31'd0, cap_busy}, 32'd0);
        chk("rst_done", {31'd0, cap_done}, 32'd0);
        chk("rst_errs", {29'd0, err_len, err_frame, err_tmo}, 32'd0);
        s_rst = 1'b0;
        tick();

        // Single shot: a line before FS is not captured
        request(1'b0);
        chk("ss_busy", {31'd0, cap_busy}, 32'd1);
        send_line(4, 16'h0A00, 1'b0);
        chk("ss_armed_no_le", {31'd0, csi.line_end}, 32'd0);
        tick();
        fs_base = n_fs;
        le_base = n_le;
        send_fs();
        chk("ss_fs", {31'd0, csi.frame_start}, 32'd1);
        chk("ss_fs_lc", {28'd0, line_cnt}, 32'd0);
        send_line(4, 16'h0100, 1'b1);
        chk("ss_le1", {31'd0, csi.line_end}, 32'd1);
        chk("ss_lc1", {28'd0, line_cnt}, 32'd1);
        chk("ss_fe_early", {31'd0, csi.frame_end}, 32'd0);
        tick();
        send_line(4, 16'h0200, 1'b1);
        chk("ss_le2", {31'd0, csi.line_end}, 32'd1);
        chk("ss_fe", {31'd0, csi.frame_end}, 32'd1);
        chk("ss_done", {31'd0, cap_done}, 32'd1);
        chk("ss_lc2", {28'd0, line_cnt}, 32'd2);
        chk("ss_idle", {31'd0, cap_busy}, 32'd0);
        tick();
        chk("ss_done_pulse", {31'd0, cap_done}, 32'd0);
        chk("ss_le_count", n_le - le_base, 32'd2);
        chk("ss_fs_count", n_fs - fs_base, 32'd1);
        chk("ss_len_ok", {31'd0, err_len}, 32'd0);

        // Timeout with a short-packet packet_done inside the window
        request(1'b0);
        send_fs();
        for (int i = 1; i <= TM; i++) begin
            csi.packet_done = (i == 5);
            tick();
            csi.packet_done = 1'b0;
            if (i == 5) chk("sp_no_le", {31'd0, csi.line_end}, 32'd0);
            if (i == TM - 1) begin
                chk("tmo_not_yet", {31'd0, err_tmo}, 32'd0);
                chk("tmo_fe_not_yet", {31'd0, csi.frame_end}, 32'd0);
            end
        end
        chk("tmo_err", {31'd0, err_tmo}, 32'd1);
        chk("tmo_fe", {31'd0, csi.frame_end}, 32'd1);
        chk("tmo_done", {31'd0, cap_done}, 32'd1);
        chk("tmo_idle", {31'd0, cap_busy}, 32'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("tmo_clr", {31'd0, err_tmo}, 32'd0);

        // Short line: still forwarded and counted
        request(1'b0);
        send_fs();
        send_line(3, 16'h0300, 1'b1);
        chk("short_le", {31'd0, csi.line_end}, 32'd1);
        chk("short_lc", {28'd0, line_cnt}, 32'd1);
        chk("short_len", {31'd0, err_len}, {31'd0, LEN_EXP});
        tick();
        send_line(4, 16'h0400, 1'b1);
        chk("short_fe", {31'd0, csi.frame_end}, 32'd1);
        chk("short_len_sticky", {31'd0, err_len}, {31'd0, LEN_EXP});
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("short_len_clr", {31'd0, err_len}, 32'd0);

        // Early FS in continuous mode restarts the frame
        request(1'b1);
        send_fs();
        send_line(4, 16'h0500, 1'b1);
        chk("ef_lc1", {28'd0, line_cnt}, 32'd1);
        tick();
        send_fs();
        chk("ef_fe", {31'd0, csi.frame_end}, 32'd1);
        chk("ef_fs", {31'd0, csi.frame_start}, 32'd1);
        chk("ef_err", {31'd0, err_frame}, 32'd1);
        chk("ef_lc0", {28'd0, line_cnt}, 32'd0);
        chk("ef_no_done", {31'd0, cap_done}, 32'd0);
        chk("ef_busy", {31'd0, cap_busy}, 32'd1);
        stop_pulse();
        send_line(4, 16'h0600, 1'b1);
        tick();
        send_line(4, 16'h0700, 1'b1);
        chk("ef_end_fe", {31'd0, csi.frame_end}, 32'd1);
        chk("ef_end_done", {31'd0, cap_done}, 32'd1);
        chk("ef_end_idle", {31'd0, cap_busy}, 32'd0);
        tick();

        // Continuous: three FS, stop during frame 2
        fs_base = n_fs;
        request(1'b1);
        send_fs();
        send_line(4, 16'h1000, 1'b1);
        tick();
        send_line(4, 16'h1100, 1'b1);
        chk("c1_fe", {31'd0, csi.frame_end}, 32'd1);
        chk("c1_no_done", {31'd0, cap_done}, 32'd0);
        chk("c1_rearm", {31'd0, cap_busy}, 32'd1);
        tick();
        send_fs();
        chk("c2_fs", {31'd0, csi.frame_start}, 32'd1);
        send_line(4, 16'h2000, 1'b1);
        stop_pulse();
        chk("c2_busy_after_stop", {31'd0, cap_busy}, 32'd1);
        send_line(4, 16'h2100, 1'b1);
        chk("c2_fe", {31'd0, csi.frame_end}, 32'd1);
        chk("c2_done", {31'd0, cap_done}, 32'd1);
        chk("c2_idle", {31'd0, cap_busy}, 32'd0);
        tick();
        send_fs();
        chk("c3_no_fs", {31'd0, csi.frame_start}, 32'd0);
        send_line(4, 16'h3000, 1'b0);
        chk("c3_no_le", {31'd0, csi.line_end}, 32'd0);
        tick();
        chk("c_fs_count", n_fs - fs_base, 32'd2);
        chk("c_err_frame_kept", {31'd0, err_frame}, 32'd1);

        // Stop while ARMED
        request(1'b1);
        stop_pulse();
        chk("arm_stop_done", {31'd0, cap_done}, 32'd1);
        chk("arm_stop_idle", {31'd0, cap_busy}, 32'd0);
        tick();

        // Reset in the middle of a line
        request(1'b0);
        send_fs();
        for (int i = 0; i < 2; i++) begin
            csi.raw_vld  = 1'b1;
            csi.raw_data = 16'h4000 + 16'(i);
            exp_q.push_back(16'h4000 + 16'(i));
            tick();
        end
        s_rst        = 1'b1;
        csi.raw_data = 16'h4002;
        tick();
        chk("mr_pix_vld", {31'd0, csi.pix_vld}, 32'd0);
        chk("mr_busy", {31'd0, cap_busy}, 32'd0);
        chk("mr_fe", {31'd0, csi.frame_end}, 32'd0);
        chk("mr_done", {31'd0, cap_done}, 32'd0);
        chk("mr_lc", {28'd0, line_cnt}, 32'd0);
        chk("mr_err_frame", {31'd0, err_frame}, 32'd0);
        s_rst       = 1'b0;
        csi.raw_vld = 1'b0;
        tick();
        tick();

        chk("pix_remaining", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/csi_frame_ctrl.md
# csi_frame_ctrl

Frame-capture controller between the CSI-2 packet handler and the frame-buffer write path. It consumes the handler's per-line RAW10/RAW-word stream, line-done and frame-start strobes. It arms on a capture request and gates exactly one frame, or frames continuously, aligned to frame start. It emits registered pixel words with line and frame framing pulses, and flags malformed lines, frames and stalls.

## Interface
Parameters:
- H_WORDS, 1280: expected 16-bit words per line (must be ≥2).
- V_LINES, 720: expected lines per frame.
- TMO_CYC, 65535: max cycles in ACTIVE without a line end before timeout.
- LCW, 12: width of line counter (2^LCW > V_LINES).

Ports:
- sclk  in  1  system clock; one clock domain.
- s_rst  in  1  synchronous, active-high reset.
- raw_vld  in  1  handler word valid (high for contiguous words of one long packet).
- raw_data  in  16  handler word.
- raw_vsync  in  1  one-cycle frame-start strobe (FS short packet).
- packet_done  in  1  one-cycle end-of-packet strobe (long or short packet).
- cap_req  in  1  one-cycle capture request.
- cap_cont  in  1  continuous mode level; sampled on cap_req.
- cap_stop  in  1  one-cycle stop request (continuous mode).
- err_clr  in  1  clears sticky error flags.
- pix_vld  out  1  registered word valid.
- pix_data  out  16  registered word; 0 when pix_vld=0.
- frame_start  out  1  pulse, first cycle of a captured frame.
- line_end  out  1  pulse after last word of each captured line.
- frame_end  out  1  pulse when a captured frame terminates (normal or error).
- line_cnt  out  LCW  lines completed in current frame.
- cap_busy  out  1  high in ARMED or ACTIVE.
- cap_done  out  1  pulse when controller returns to IDLE.
- err_len  out  1  sticky: line word count ≠ H_WORDS.
- err_frame  out  1  sticky: raw_vsync arrived before V_LINES lines completed.
- err_tmo  out  1  sticky: ACTIVE timeout.

## Operation
- States: IDLE, ARMED, ACTIVE.
- IDLE: cap_req → ARMED; latch cont = cap_cont.
- ARMED: raw_vsync → ACTIVE, frame_start=1, line_cnt=0, word counter=0.
- ACTIVE: raw_vld words forwarded; word counter increments per raw_vld cycle (saturates at all-ones).
- Line end detect: packet_done=1 while raw_vld_d1=1 (previous cycle valid). Short-packet packet_done, with raw_vld_d1=0, is ignored.
- On line end: line_end=1, line_cnt+1, word counter=0, timeout counter=0.
- Frame complete: line end bringing line_cnt to V_LINES → frame_end=1. Then go to ARMED if cont and no pending stop, else IDLE with cap_done=1.
- raw_vsync in ACTIVE before completion: frame_end=1 and err_frame set. If cont, immediately start new frame (frame_start=1, counters cleared, stay ACTIVE). Else IDLE, cap_done.
- Timeout: timeout counter increments each ACTIVE cycle, cleared on line end. Reaching TMO_CYC → err_tmo, frame_end, then ARMED (cont) / IDLE+cap_done.
- cap_stop: clears cont; takes effect at next frame termination. In ARMED, cap_stop → IDLE with cap_done immediately.
- cap_req while busy: ignored.
- err_clr: clears all sticky flags. A set event in the same cycle wins.

## Timing
- Reset: state IDLE; all outputs 0, including line_cnt and sticky errors; cont=0.
- pix_vld/pix_data: 1-cycle latency from raw_vld/raw_data, only for words entering in ACTIVE. The first word of a line is gated out if the FS edge has not yet moved the state to ACTIVE.
- frame_start: asserted the cycle after the raw_vsync strobe.
- line_end: asserted the cycle after packet_done, i.e. 2 cycles after the last raw_vld.
- frame_end coincides with the terminating line_end / error pulse. cap_done coincides with frame_end when returning to IDLE.
- line_cnt updates in the same cycle as line_end.
- Reset mid-frame: s_rst returns to IDLE in one cycle; no frame_end or cap_done is emitted.

## Configuration
- FRAME_CTRL_LINE_CHK_EN defined: at each line end, word count ≠ H_WORDS sets err_len. The line is still forwarded and counted.
- Not defined: no word-count comparison logic; err_len tied 0; word counter omitted.

## Test plan
- Single shot, H_WORDS=4, V_LINES=2: cap_req, FS, 2 lines of 4 words → 8 pix_vld, 2 line_end, frame_end+cap_done together, cap_busy 0 after.
- Continuous: cap_cont=1, 3 frames, cap_stop during frame 2 → frame_start ×2, IDLE after frame 2 end; frame 3 data ignored, pix_vld stays 0.
- Short line (3 words, LINE_CHK_EN on) → err_len=1 persisting until err_clr; with macro off err_len stays 0.
- FS after 1 of 2 lines, cont=1 → frame_end, err_frame=1, new frame_start next cycle, line_cnt=0.
- TMO_CYC=16, FS then no data → err_tmo at cycle 16 of ACTIVE, frame_end, cap_done (single shot).
- Short-packet packet_done (raw_vld_d1=0) in ACTIVE → no line_end; s_rst mid-line → all outputs 0 next cycle.
